// File: rtl/score_display_ctrl.sv
// Score display controller: latches a binary score, converts it to BCD with a
// sequential shift-add-3, and time-multiplexes the digits onto one decoder.

module score_display_bcd_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

module score_display_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int SCORE_W    = 14,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SCORE_W-1:0]    score_in,
  input  logic                  score_load,
  output logic                  busy,
  output logic                  overflow,
  output logic [3:0]            digit_num,
  output logic [NUM_DIGITS-1:0] digit_en
);
  localparam int BW = 4 * NUM_DIGITS;
  localparam int RW = BW + SCORE_W;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(SCORE_W + 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] MAXV = pow10(NUM_DIGITS) - 64'd1;

  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

  state_t              state_q, state_d;
  logic [RW-1:0]       sr;
  logic [CW-1:0]       cnt;
  logic [BW-1:0]       shown;
  logic [BW-1:0]       bcd_adj;
  logic [IW-1:0]       idx;
  logic [PW-1:0]       presc;
  logic                ovf_q;
  logic                over_max;
  logic [SCORE_W-1:0]  sat_score;
  logic [NUM_DIGITS-1:0] lz;

  assign over_max  = 64'(score_in) > MAXV;
  assign sat_score = over_max ? MAXV[SCORE_W-1:0] : score_in;

  // One +3 adjuster per BCD digit, all applied before the shift
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
    score_display_bcd_adj u_adj (
      .din  (sr[SCORE_W + 4*g +: 4]),
      .dout (bcd_adj[4*g +: 4])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    case (state_q)
      IDLE:    if (score_load) state_d = CONVERT;
      CONVERT: begin
        busy = 1'b1;
        if (cnt == CW'(SCORE_W - 1)) state_d = COMMIT;
      end
      COMMIT:  begin
        busy    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr    <= '0;
      cnt   <= '0;
      shown <= '0;
      ovf_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (score_load) begin
          sr    <= {{BW{1'b0}}, sat_score};
          cnt   <= '0;
          ovf_q <= over_max;
        end
        CONVERT: begin
          sr  <= {bcd_adj[BW-2:0], sr[SCORE_W-1:0], 1'b0};
          cnt <= cnt + 1'b1;
        end
        COMMIT: shown <= sr[RW-1 -: BW];
        default: ;
      endcase
    end
  end

  // Free-running digit scan, unaffected by conversions
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PW'(SCAN_DIV - 1)) begin
      presc <= '0;
      idx   <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // lz[g]: digit g and every higher digit are zero
  assign lz[NUM_DIGITS-1] = (shown[BW-1 -: 4] == 4'd0);
  for (genvar g = 0; g < NUM_DIGITS - 1; g++) begin : g_lz
    assign lz[g] = lz[g+1] && (shown[4*g +: 4] == 4'd0);
  end

  assign overflow  = ovf_q;
  assign digit_num = shown[4*idx +: 4];
  assign digit_en  = (idx != '0 && lz[idx]) ? '1
                                            : ~(NUM_DIGITS'(1) << idx);

endmodule
